// File: rtl/maquina_pkg.sv
// maquina_pkg: state type and encodings shared by the controller and the status decode.
package maquina_pkg;
  typedef logic [3:0] state_t;
  localparam state_t IDLE                = 4'd1;
  localparam state_t LIGAR_MAQUINA       = 4'd2;
  localparam state_t VERIFICAR_AGUA      = 4'd3;
  localparam state_t ENCHER_RESERVATORIO = 4'd4;
  localparam state_t MOER_CAFE           = 4'd5;
  localparam state_t COLOCAR_NO_FILTRO   = 4'd6;
  localparam state_t PASSAR_AGITADOR     = 4'd7;
  localparam state_t TAMPEAR             = 4'd8;
  localparam state_t REALIZAR_EXTRACAO   = 4'd9;
endpackage

// File: rtl/maquina_maluca_multi_dwell_timer.sv
// maquina_dwell_timer: counts cycles spent in the current state; last marks the final dwell cycle.
module maquina_dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] dwell,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else        cnt <= clear ? '0 : cnt + 1'b1;
  assign last = cnt == dwell - 1'b1;
endmodule

// File: rtl/maquina_maluca_multi.sv
// maquina_maluca_multi: multi-cup coffee controller with dose-counted reservoir, timed steps and abort.
// Define MAQUINA_STATS_EN to build the saturating cups_served counter.
module maquina_maluca_multi
  import maquina_pkg::*;
#(
  parameter int WATER_MAX   = 4,
  parameter int STEP_CYCLES = 2,
  parameter int FILL_CYCLES = 3,
  parameter int CUP_W       = 3,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CUP_W-1:0]               cups,
  input  logic                           abort,
  output state_t                         state,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(WATER_MAX+1)-1:0] water_level,
  output logic [CUP_W-1:0]               cups_left,
  output logic [CNT_W-1:0]               cups_served
);
  localparam int WL_W = $clog2(WATER_MAX+1);
  localparam int DMAX = STEP_CYCLES > FILL_CYCLES ? STEP_CYCLES : FILL_CYCLES;
  localparam int DW_W = $clog2(DMAX+1);
  state_t state_nxt;
  logic last, kill, fill_end, cup_end;
  assign busy     = state != IDLE;
  assign kill     = abort && busy;
  assign fill_end = state == ENCHER_RESERVATORIO && last && !kill;
  assign cup_end  = state == REALIZAR_EXTRACAO && last && !kill;
  maquina_dwell_timer #(.W(DW_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_nxt != state),
    .dwell (state == ENCHER_RESERVATORIO ? DW_W'(FILL_CYCLES) : DW_W'(STEP_CYCLES)),
    .last  (last)
  );
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:                if (start && cups != '0) state_nxt = LIGAR_MAQUINA;
      LIGAR_MAQUINA:       state_nxt = VERIFICAR_AGUA;
      VERIFICAR_AGUA:      state_nxt = water_level == '0 ? ENCHER_RESERVATORIO : MOER_CAFE;
      ENCHER_RESERVATORIO: if (last) state_nxt = VERIFICAR_AGUA;
      MOER_CAFE:           if (last) state_nxt = COLOCAR_NO_FILTRO;
      COLOCAR_NO_FILTRO:   state_nxt = PASSAR_AGITADOR;
      PASSAR_AGITADOR:     state_nxt = TAMPEAR;
      TAMPEAR:             state_nxt = REALIZAR_EXTRACAO;
      REALIZAR_EXTRACAO:   if (last) state_nxt = cups_left == CUP_W'(1) ? IDLE : VERIFICAR_AGUA;
      default:             state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      water_level <= '0;
      cups_left   <= '0;
    end else begin
      state <= state_nxt;
      done  <= cup_end && cups_left == CUP_W'(1);
      if (fill_end)     water_level <= WL_W'(WATER_MAX);
      else if (cup_end) water_level <= water_level - 1'b1;
      if (state == IDLE && start && cups != '0) cups_left <= cups;
      else if (kill)                            cups_left <= '0;
      else if (cup_end)                         cups_left <= cups_left - 1'b1;
    end
`ifdef MAQUINA_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                       cups_served <= '0;
    else if (cup_end && ~&cups_served) cups_served <= cups_served + 1'b1;
`else
  assign cups_served = '0;
`endif
endmodule

// File: tb/tb_maquina_maluca_multi.sv
// tb_maquina_maluca_multi: directed checks of sequencing, reservoir, multi-cup orders, abort and statistics.
module tb_maquina_maluca_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cups = '0;
  logic       abort = 1'b0;
  logic [3:0] state;
  logic       busy, done;
  logic [2:0] water_level, cups_left;
  logic [1:0] cups_served;
  int n_checks = 0;
  int n_errors = 0;
  int served = 0;
  int cyc, fills, dones;
  always #5 clk = ~clk;
  maquina_maluca_multi #(.CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cups        (cups),
    .abort       (abort),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .water_level (water_level),
    .cups_left   (cups_left),
    .cups_served (cups_served)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_served();
`ifdef MAQUINA_STATS_EN
    return served > 3 ? 3 : served;
`else
    return 0;
`endif
  endfunction
  task automatic run_order(input logic [2:0] n, output int c, output int f, output int d);
    c = 0; f = 0; d = 0;
    start = 1'b1; cups = n;
    @(negedge clk);
    start = 1'b0;
    while (state != 4'd1 && c < 500) begin
      c++;
      if (state == 4'd4) f++;
      if (done) d++;
      @(negedge clk);
    end
  endtask
  initial begin
    static logic [3:0] seq1 [14] = '{2,3,4,4,4,3,5,5,6,7,8,9,9,1};
    int k;
    #12;
    check("rst_state", state, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_water", water_level, 0);
    check("rst_cups_left", cups_left, 0);
    check("rst_served", cups_served, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // one cup, empty reservoir
    start = 1'b1; cups = 3'd1;
    check("o1_idle", state, 1);
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("o1_seq%0d", i), state, seq1[i]);
      check($sformatf("o1_busy%0d", i), busy, seq1[i] != 4'd1);
      if (done) dones++;
    end
    served = 1;
    check("o1_done_end", done, 1);
    check("o1_done_count", dones, 1);
    check("o1_water", water_level, 3);
    check("o1_served", cups_served, exp_served());
    // three cups back-to-back on the done edge, reservoir holds exactly three doses
    run_order(3'd3, cyc, fills, dones);
    served = 4;
    check("o2_cycles", cyc, 25);
    check("o2_fills", fills, 0);
    check("o2_early_done", dones, 0);
    check("o2_done_end", done, 1);
    check("o2_water", water_level, 0);
    check("o2_cups_left", cups_left, 0);
    check("o2_served", cups_served, exp_served());
    // three cups from empty: one refill, ends with one dose
    run_order(3'd3, cyc, fills, dones);
    served = 7;
    check("o3_cycles", cyc, 29);
    check("o3_fills", fills, 3);
    check("o3_water", water_level, 1);
    check("o3_done_end", done, 1);
    check("o3_served", cups_served, exp_served());
    // two cups with one dose: second cup refills
    run_order(3'd2, cyc, fills, dones);
    served = 9;
    check("o4_cycles", cyc, 21);
    check("o4_fills", fills, 3);
    check("o4_water", water_level, 3);
    check("o4_done_end", done, 1);
    check("o4_served", cups_served, exp_served());
    // abort on the final extraction cycle
    @(negedge clk);
    start = 1'b1; cups = 3'd1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (state != 4'd9 && k < 50) begin k++; @(negedge clk); end
    check("ab_reach_ext", state, 9);
    @(negedge clk);
    check("ab_last_ext", state, 9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_state", state, 1);
    check("ab_done", done, 0);
    check("ab_water", water_level, 3);
    check("ab_cups_left", cups_left, 0);
    check("ab_served", cups_served, exp_served());
    @(negedge clk);
    check("ab_no_late_done", done, 0);
    // abort ignored in IDLE, then effective once busy
    start = 1'b1; cups = 3'd2; abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ai_started", state, 2);
    check("ai_cups_left", cups_left, 2);
    @(negedge clk);
    abort = 1'b0;
    check("ai_aborted", state, 1);
    check("ai_cups_cleared", cups_left, 0);
    check("ai_done", done, 0);
    // zero-cup request ignored
    start = 1'b1; cups = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("z_state%0d", i), state, 1);
      check($sformatf("z_busy%0d", i), busy, 0);
    end
    start = 1'b0;
    // asynchronous reset mid-order
    start = 1'b1; cups = 3'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ar_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    served = 0;
    check("ar_state", state, 1);
    check("ar_water", water_level, 0);
    check("ar_cups_left", cups_left, 0);
    check("ar_served", cups_served, exp_served());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/maquina_maluca_multi.md
# maquina_maluca_multi

Parametrised successor of the single-cup coffee-machine controller. It keeps the same 4-bit state encoding and step sequence, and adds:
- multi-cup orders;
- a reservoir tracked as a dose counter rather than a full/empty flag;
- timed dwell in the grind, fill and extraction steps;
- an abort input.

It sits between the front-panel request logic and the actuator/status decode, which consumes `state`.

## Interface
Parameters:
- `WATER_MAX`, default 4: reservoir capacity in doses; ≥1.
- `STEP_CYCLES`, default 2: dwell cycles in MOER_CAFE and REALIZAR_EXTRACAO; ≥1.
- `FILL_CYCLES`, default 3: dwell cycles in ENCHER_RESERVATORIO; ≥1.
- `CUP_W`, default 3: width of the cup-count request.
- `CNT_W`, default 16: width of the served-cups statistic.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst_n`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  order request, sampled in IDLE only.
- `cups`  in  CUP_W  cups in the order, latched with `start`.
- `abort`  in  1  cancels the order in progress.
- `state`  out  4  current state: IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5, COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9.
- `busy`  out  1  `state != IDLE`.
- `done`  out  1  one-cycle pulse when an order completes.
- `water_level`  out  $clog2(WATER_MAX+1)  doses left in the reservoir.
- `cups_left`  out  CUP_W  cups remaining in the current order.
- `cups_served`  out  CNT_W  total cups extracted since reset.

## Operation
- **Reset:** `state`=IDLE; `water_level`, `cups_left`, `cups_served`, `done` and the dwell counter are all 0.
- **IDLE:**
  - `start && cups!=0` → LIGAR_MAQUINA, with `cups_left<=cups`.
  - `start` with `cups==0` is ignored.
- **LIGAR_MAQUINA** → VERIFICAR_AGUA.
- **VERIFICAR_AGUA:** `water_level==0` → ENCHER_RESERVATORIO; otherwise → MOER_CAFE.
- **ENCHER_RESERVATORIO:** held FILL_CYCLES cycles. On the last cycle, `water_level<=WATER_MAX` and the next state is VERIFICAR_AGUA.
- **MOER_CAFE:** held STEP_CYCLES cycles, then → COLOCAR_NO_FILTRO.
- **COLOCAR_NO_FILTRO** → PASSAR_AGITADOR → TAMPEAR → REALIZAR_EXTRACAO, one cycle each.
- **REALIZAR_EXTRACAO:** held STEP_CYCLES cycles. On the last cycle:
  - `water_level` decrements by 1;
  - `cups_left` decrements by 1;
  - `cups_served` increments by 1.
  - If `cups_left==1`, go to IDLE and pulse `done`. Otherwise go to VERIFICAR_AGUA; subsequent cups skip LIGAR_MAQUINA.
- **Dwell counter:** cleared on every state entry. A dwell of N holds the state exactly N cycles.
- **Abort:** `abort` high in any non-IDLE state gives IDLE next cycle and `cups_left<=0`. No `done` pulse. `water_level` is unchanged.
  - Abort has priority over dwell completion. Abort on the final extraction cycle means the cup is not counted and no dose is consumed.
  - Abort in IDLE has no effect.
- **Persistence:** `water_level` persists across orders; only reset empties it.
- **Invariant:** `water_level` never underflows, because extraction is only reachable via VERIFICAR_AGUA with level ≥1.

## Timing
- All outputs are registered except `busy`, which decodes the `state` register.
- One cup with a non-empty reservoir: 5+2·STEP_CYCLES cycles in non-IDLE states. `done` is high in the first IDLE cycle after that. With defaults this is 9 busy cycles.
- An empty reservoir adds FILL_CYCLES+1 cycles (fill plus re-check).
- Each additional cup adds 4+2·STEP_CYCLES cycles, plus the fill penalty if the reservoir empties.
- A new `start` is accepted on the same edge that `done` is high, since `state` is already IDLE.
- Reset mid-operation asynchronously forces all reset values; the current order is lost.

## Configuration
- `MAQUINA_STATS_EN` defined: `cups_served` is a CNT_W counter that saturates at all-ones.
- `MAQUINA_STATS_EN` undefined: no counter is built and `cups_served` is tied to 0.

## Structure
- Package `maquina_pkg` holds:
  - the 4-bit `state_t` typedef;
  - the nine state encoding constants, shared with the status decode.
- Sub-module `maquina_dwell_timer`:
  - clears on state change;
  - asserts `last` when the count reaches the selected dwell minus 1.

## Test plan
- Reset, then `start`, `cups=1`, empty reservoir, defaults → state sequence 1,2,3,4,4,4,3,5,5,6,7,8,9,9,1; `done` high once; `water_level`=3.
- Next order `cups=3` with `water_level=3` → three extractions, no ENCHER; `water_level`=0, `cups_served`=4; `done` high once, at the end.
- `cups=2` with `water_level=1` → the second cup passes VERIFICAR→ENCHER; final `water_level`=3.
- `abort` on the last REALIZAR_EXTRACAO cycle → IDLE next cycle; `cups_served` and `water_level` unchanged; no `done`.
- `start` with `cups=0` → remains IDLE; `busy`=0.
- With MAQUINA_STATS_EN and CNT_W=2 → `cups_served` saturates at 3 after 4 cups. Without the macro, it reads 0 throughout.
